dma_sequencer: RTL
==================

Name: dma_sequencer

Overview:
- Programmable controller that drives the DMA master's word-level request interface.
- CPU programs source address, destination address and word count through a small register port, then starts the transfer.
- Block alternates single-word reads and writes, increments both addresses by 4, raises an interrupt on completion or error, and supports a clean abort at word boundaries.
- Sits between the CPU-side config bus and the DMA master; one instance per DMA channel.

Parameters:
ADDR_W, 32, byte address width of src/dst
DATA_W, 32, data word width; byte strobe width is DATA_W/8
LEN_W, 16, width of the word-count register

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  config register write strobe
cfg_addr  in  2  register select: 0=SRC, 1=DST, 2=LEN, 3=CTRL(write)/STATUS(read)
cfg_wdata  in  32  config write data
cfg_rdata  out  32  combinational readback of the selected register
mst_req  out  1  transaction request to DMA master, level, held until mst_ack
mst_write  out  1  0=read, 1=write; stable while mst_req=1
mst_addr  out  ADDR_W  transaction address
mst_wdata  out  DATA_W  write data (buffered read word)
mst_wstrb  out  DATA_W/8  all ones during writes, 0 otherwise
mst_ack  in  1  one-cycle pulse: transaction finished (RLast or BValid handshake)
mst_rdata  in  DATA_W  read data, valid with mst_ack on reads
mst_err  in  1  response not OKAY, valid with mst_ack
busy  out  1  transfer in progress
irq  out  1  level interrupt = STATUS.done | STATUS.err

Behaviour:
- Reset, asynchronous and immediate: FSM=IDLE; SRC/DST/LEN/buffer/remaining=0; all flags clear.
- Outputs during reset: mst_req=0, mst_write=0, mst_wstrb=0, busy=0, irq=0.
- CTRL write bits: bit0 start, bit1 clear done/err/aborted (W1C), bit2 abort request.
- Same CTRL write with both bit1 and bit0: clear is applied first, then start.
- STATUS read bits: [0] busy, [1] done, [2] err, [3] aborted, [31:16] remaining count.
- SRC/DST/LEN writes while busy=1 are ignored. Start while busy=1 is ignored.
- Start with LEN=0: no transaction is issued; done=1 on the next cycle.
- FSM states: IDLE, RD_REQ, WR_REQ, FINISH, ERROR.
- IDLE -> RD_REQ on accepted start. Captures cur_src=SRC, cur_dst=DST, remaining=LEN. mst_req rises on the cycle after the CTRL write.
- RD_REQ: mst_req=1, mst_write=0, mst_addr=cur_src.
  - On mst_ack & !mst_err: buffer<=mst_rdata, cur_src+=4, go to WR_REQ. mst_req stays high with no idle cycle between read and write.
- WR_REQ: mst_req=1, mst_write=1, mst_addr=cur_dst, mst_wdata=buffer.
  - On mst_ack & !mst_err: cur_dst+=4, remaining-=1.
  - Then go to FINISH if remaining was 1 or abort is pending; otherwise go to RD_REQ.
- mst_ack & mst_err in either request state -> ERROR. Address and remaining values stay frozen.
- FINISH: one cycle. Sets done=1 (aborted=1 if abort was pending), clears the pending abort, busy=0, then IDLE.
- ERROR: one cycle. Sets err=1, busy=0, then IDLE.
- busy=1 in RD_REQ and WR_REQ only.
- Abort is sticky-pending until honoured and is only acted on after a write ack, so the current word always completes.
  - Abort in IDLE is ignored.
  - Abort and mst_ack in the same cycle count as pending for that ack.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0 with no error.
- mst_ack seen in IDLE/FINISH/ERROR is ignored.
- A new start is accepted from IDLE even when done or err is still set; those flags remain until cleared via bit1.

Decomposition:
- Shared package dma_pkg holds:
  - state enum;
  - register offsets;
  - CTRL/STATUS bit indices;
  - address step constant (4);
  - AXI response codes.
- One sub-module, dma_seq_regs: SRC/DST/LEN storage, W1C flag logic and cfg_rdata mux.
- The FSM, buffer and counters stay in the top level.

Test Plan:
- SRC=0x1000, DST=0x2000, LEN=3, start, ack each request after 2 cycles -> reads 0x1000/0x1004/0x1008 interleaved with writes 0x2000/0x2004/0x2008; wdata equals the preceding rdata; irq=1, STATUS=0x0000_0002.
- LEN=0, start -> no mst_req for 10 cycles; done=1 on the cycle after the start write; W1C clear -> irq=0.
- LEN=4, abort asserted during the 2nd read -> 2nd write completes, no 3rd read; STATUS.aborted=1, done=1, remaining=2.
- LEN=2, mst_err with the first write ack -> ERROR; err=1, irq=1, remaining=2; no further requests issued.
- SRC=0xFFFF_FFFC, LEN=2 -> second read address is 0x0000_0000.
- Assert rst while mst_req=1 in WR_REQ -> mst_req=0 in the same cycle (asynchronous); all STATUS=0; writes to SRC/DST/LEN take effect again after reset is released.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA sequencer: FSM encoding, register map,
// CTRL/STATUS bit positions, address step and AXI response codes.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_WR_REQ = 3'd2,
    ST_FINISH = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_REM_LSB = 16;

  // Sticky completion flags, indexed into a small vector
  localparam int FLAG_DONE    = 0;
  localparam int FLAG_ERR     = 1;
  localparam int FLAG_ABORTED = 2;
  localparam int NUM_FLAGS    = 3;

  localparam int ADDR_STEP = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/dma_seq_regs.sv
// CPU-facing register file: SRC/DST/LEN storage, CTRL decode, sticky
// done/err/aborted flags with write-one-to-clear, and the readback mux.
module dma_seq_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  input  logic                 busy,
  input  logic [LEN_W-1:0]     remaining,
  input  logic [NUM_FLAGS-1:0] flag_set,
  output logic [ADDR_W-1:0]    src,
  output logic [ADDR_W-1:0]    dst,
  output logic [LEN_W-1:0]     len,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 start_req,
  output logic                 abort_req
);

  logic [ADDR_W-1:0]    src_reg;
  logic [ADDR_W-1:0]    dst_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [NUM_FLAGS-1:0] flag_reg;
  logic                 ctrl_wr;
  logic                 clear_req;
  logic [31:0]          status_word;

  assign ctrl_wr   = cfg_we && (cfg_addr == REG_CTRL);
  assign start_req = ctrl_wr && cfg_wdata[CTRL_START];
  assign clear_req = ctrl_wr && cfg_wdata[CTRL_CLEAR];
  assign abort_req = ctrl_wr && cfg_wdata[CTRL_ABORT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        REG_SRC: src_reg <= ADDR_W'(cfg_wdata);
        REG_DST: dst_reg <= ADDR_W'(cfg_wdata);
        REG_LEN: len_reg <= LEN_W'(cfg_wdata);
        default: ;
      endcase
    end
  end

  // A set in the same cycle as a clear wins, so clear+start with LEN=0 leaves done=1
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flag_reg[gi] <= 1'b0;
        end else begin
          flag_reg[gi] <= (flag_reg[gi] && !clear_req) || flag_set[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    status_word                           = '0;
    status_word[STAT_BUSY]                = busy;
    status_word[STAT_DONE]                = flag_reg[FLAG_DONE];
    status_word[STAT_ERR]                 = flag_reg[FLAG_ERR];
    status_word[STAT_ABORTED]             = flag_reg[FLAG_ABORTED];
    status_word[STAT_REM_LSB +: 16]       = 16'(remaining);
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_SRC:  cfg_rdata = 32'(src_reg);
      REG_DST:  cfg_rdata = 32'(dst_reg);
      REG_LEN:  cfg_rdata = 32'(len_reg);
      default:  cfg_rdata = status_word;
    endcase
  end

  assign src   = src_reg;
  assign dst   = dst_reg;
  assign len   = len_reg;
  assign flags = flag_reg;

endmodule

// File: rtl/dma_sequencer.sv
// Single-channel DMA sequencer: alternates one-word reads and writes on the
// master request port, advancing both addresses by one word per beat.
module dma_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           cfg_rdata,
  output logic                  mst_req,
  output logic                  mst_write,
  output logic [ADDR_W-1:0]     mst_addr,
  output logic [DATA_W-1:0]     mst_wdata,
  output logic [DATA_W/8-1:0]   mst_wstrb,
  input  logic                  mst_ack,
  input  logic [DATA_W-1:0]     mst_rdata,
  input  logic                  mst_err,
  output logic                  busy,
  output logic                  irq
);

  state_t               state_reg;
  state_t               state_next;
  logic [ADDR_W-1:0]    cur_src_reg;
  logic [ADDR_W-1:0]    cur_dst_reg;
  logic [LEN_W-1:0]     remaining_reg;
  logic [DATA_W-1:0]    buffer_reg;
  logic                 abort_pending_reg;

  logic [ADDR_W-1:0]    src;
  logic [ADDR_W-1:0]    dst;
  logic [LEN_W-1:0]     len;
  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_FLAGS-1:0] flag_set;
  logic                 start_req;
  logic                 abort_req;
  logic                 start_ok;
  logic                 abort_now;
  logic                 last_word;

  dma_seq_regs #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .busy      (busy),
    .remaining (remaining_reg),
    .flag_set  (flag_set),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .flags     (flags),
    .start_req (start_req),
    .abort_req (abort_req)
  );

  assign start_ok  = start_req && (state_reg == ST_IDLE);
  // An abort arriving with the write ack still stops the transfer after that word
  assign abort_now = abort_pending_reg || abort_req;
  assign last_word = (remaining_reg == LEN_W'(1));

  assign flag_set[FLAG_DONE]    = (state_reg == ST_FINISH) || (start_ok && (len == '0));
  assign flag_set[FLAG_ERR]     = (state_reg == ST_ERROR);
  assign flag_set[FLAG_ABORTED] = (state_reg == ST_FINISH) && abort_pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok && (len != '0)) begin
          state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mst_ack) begin
          state_next = mst_err ? ST_ERROR : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mst_ack) begin
          if (mst_err) begin
            state_next = ST_ERROR;
          end else if (last_word || abort_now) begin
            state_next = ST_FINISH;
          end else begin
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      ST_ERROR:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mst_req   = 1'b0;
    mst_write = 1'b0;
    mst_addr  = cur_src_reg;
    mst_wdata = buffer_reg;
    mst_wstrb = '0;
    busy      = 1'b0;
    irq       = flags[FLAG_DONE] || flags[FLAG_ERR];
    case (state_reg)
      ST_RD_REQ: begin
        mst_req = 1'b1;
        busy    = 1'b1;
      end
      ST_WR_REQ: begin
        mst_req   = 1'b1;
        mst_write = 1'b1;
        mst_addr  = cur_dst_reg;
        mst_wstrb = '1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath only advances on an OKAY ack, so an error leaves addresses and count frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_src_reg   <= '0;
      cur_dst_reg   <= '0;
      remaining_reg <= '0;
      buffer_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            cur_src_reg   <= src;
            cur_dst_reg   <= dst;
            remaining_reg <= len;
          end
        end
        ST_RD_REQ: begin
          if (mst_ack && !mst_err) begin
            buffer_reg  <= mst_rdata;
            cur_src_reg <= cur_src_reg + ADDR_W'(ADDR_STEP);
          end
        end
        ST_WR_REQ: begin
          if (mst_ack && !mst_err) begin
            cur_dst_reg   <= cur_dst_reg + ADDR_W'(ADDR_STEP);
            remaining_reg <= remaining_reg - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_pending_reg <= 1'b0;
    end else if ((state_reg == ST_FINISH) || (state_reg == ST_ERROR)) begin
      abort_pending_reg <= 1'b0;
    end else if (abort_req && busy) begin
      abort_pending_reg <= 1'b1;
    end
  end

endmodule
